// File: rtl/game_sequencer.sv
// game_sequencer: frame-rate game-flow controller driving the player's reset, freeze hold and lives count.
// Define INVULN_EN to add the post-respawn collision mask and its blink strobe.
module game_sequencer #(
    parameter int         LIVES_INIT     = 3,
    parameter int         DEATH_FRAMES   = 90,
    parameter int         RESPAWN_FRAMES = 30,
    parameter int         INVULN_FRAMES  = 120,
    parameter logic [7:0] START_KEY      = 8'h28,
    parameter int         GOAL_Y         = 74,
    parameter int         GOAL_X_MIN     = 120,
    parameter int         GOAL_X_MAX     = 205
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    input  logic       colliding,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       player_rst,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [2:0] game_state,
    output logic       invuln,
    output logic       blink
);

    // state     | meaning
    // ATTRACT   | idle title screen, player held in reset, waits for start key
    // PLAYING   | player and hazards move; hit or goal ends the phase
    // DYING     | death animation, world frozen for DEATH_FRAMES
    // RESPAWN   | player held in reset for RESPAWN_FRAMES
    // GAME_OVER | no lives left, waits for start key
    // WIN       | goal reached, waits for start key
    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    if (LIVES_INIT < 1 || LIVES_INIT > 3 ||
        DEATH_FRAMES < 1 || DEATH_FRAMES > 255 ||
        RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255 ||
        INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
        GOAL_Y < 0 || GOAL_Y > 1023 || GOAL_X_MIN < 0 ||
        GOAL_X_MIN > GOAL_X_MAX || GOAL_X_MAX > 1023) begin : g_bad_params
        $error("game_sequencer: parameter out of range");
    end

    localparam logic [1:0] LIVES_LOAD   = 2'(LIVES_INIT);
    localparam logic [7:0] DEATH_LOAD   = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_FRAMES - 1);

    state_t     state;
    logic [7:0] timer;
    logic       key_prev;
    logic       coll_prev;
    logic       key_now;
    logic       start_edge;
    logic       hit;
    logic       goal;

    assign game_state = state;
    assign key_now    = (keycode == START_KEY) || (keycode2 == START_KEY);
    assign start_edge = key_now & ~key_prev;
    assign hit        = colliding & ~coll_prev & ~invuln;
    assign goal       = (player_y == 10'(GOAL_Y)) &&
                        (player_x >= 10'(GOAL_X_MIN)) && (player_x <= 10'(GOAL_X_MAX));

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state      <= ATTRACT;
            lives      <= LIVES_LOAD;
            timer      <= '0;
            player_rst <= 1'b1;
            freeze     <= 1'b1;
            key_prev   <= 1'b0;
            coll_prev  <= 1'b0;
        end else begin
            key_prev  <= key_now;
            coll_prev <= colliding;
            case (state)
                ATTRACT, GAME_OVER, WIN: begin
                    if (start_edge) begin
                        lives      <= LIVES_LOAD;
                        timer      <= RESPAWN_LOAD;
                        state      <= RESPAWN;
                        player_rst <= 1'b1;
                        freeze     <= 1'b1;
                    end
                end
                RESPAWN: begin
                    if (timer == 8'd0) begin
                        state      <= PLAYING;
                        player_rst <= 1'b0;
                        freeze     <= 1'b0;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                PLAYING: begin
                    // a hit in the goal frame still costs a life
                    if (hit) begin
                        lives  <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                        timer  <= DEATH_LOAD;
                        state  <= DYING;
                        freeze <= 1'b1;
                    end else if (goal) begin
                        state  <= WIN;
                        freeze <= 1'b1;
                    end
                end
                DYING: begin
                    if (timer == 8'd0) begin
                        if (lives == 2'd0) begin
                            state <= GAME_OVER;
                        end else begin
                            timer      <= RESPAWN_LOAD;
                            state      <= RESPAWN;
                            player_rst <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                    state      <= ATTRACT;
                    timer      <= '0;
                    player_rst <= 1'b1;
                    freeze     <= 1'b1;
                end
            endcase
        end
    end

`ifdef INVULN_EN
    localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES - 1);

    logic [7:0] invuln_timer;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            invuln       <= 1'b0;
            invuln_timer <= '0;
        end else if (state == RESPAWN && timer == 8'd0) begin
            invuln       <= 1'b1;
            invuln_timer <= INVULN_LOAD;
        end else if (state != PLAYING || hit || goal) begin
            invuln       <= 1'b0;
            invuln_timer <= '0;
        end else if (invuln) begin
            if (invuln_timer == 8'd0) begin
                invuln <= 1'b0;
            end else begin
                invuln_timer <= invuln_timer - 8'd1;
            end
        end
    end

    assign blink = invuln & invuln_timer[3];
`else
    assign invuln = 1'b0;
    assign blink  = 1'b0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed test-plan steps then random frames, all checked against a phase-level model.
module tb_game_sequencer;
    localparam int         LI    = 3;
    localparam int         DF    = 90;
    localparam int         RF    = 30;
    localparam int         IFR   = 120;
    localparam logic [7:0] START = 8'h28;
    localparam int         GY    = 74;
    localparam int         GXMIN = 120;
    localparam int         GXMAX = 205;
`ifdef INVULN_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam int P_ATTRACT = 0, P_PLAYING = 1, P_DYING = 2, P_RESPAWN = 3, P_OVER = 4, P_WIN = 5;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic [7:0] keycode2  = 8'h00;
    logic       colliding = 1'b0;
    logic [9:0] player_x  = '0;
    logic [9:0] player_y  = '0;
    logic       player_rst;
    logic       freeze;
    logic [1:0] lives;
    logic [2:0] game_state;
    logic       invuln;
    logic       blink;

    int errors = 0;
    int checks = 0;

    int m_phase   = P_ATTRACT;
    int m_elapsed = 0;
    int m_lives   = LI;
    int m_play    = 0;
    bit m_key_prev  = 1'b0;
    bit m_coll_prev = 1'b0;
    bit m_invuln    = 1'b0;

    game_sequencer #(
        .LIVES_INIT(LI), .DEATH_FRAMES(DF), .RESPAWN_FRAMES(RF), .INVULN_FRAMES(IFR),
        .START_KEY(START), .GOAL_Y(GY), .GOAL_X_MIN(GXMIN), .GOAL_X_MAX(GXMAX)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode2(keycode2),
        .colliding(colliding), .player_x(player_x), .player_y(player_y),
        .player_rst(player_rst), .freeze(freeze), .lives(lives), .game_state(game_state),
        .invuln(invuln), .blink(blink)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances the phase-level model by one frame using the inputs sampled at this edge.
    task automatic model_step();
        bit key_now, sedge, hit, goal;
        key_now = (keycode == START) || (keycode2 == START);
        sedge   = key_now && !m_key_prev;
        hit     = colliding && !m_coll_prev && !m_invuln;
        goal    = (player_y == GY) && (player_x >= GXMIN) && (player_x <= GXMAX);
        if (Reset) begin
            m_phase = P_ATTRACT; m_lives = LI; m_elapsed = 0; m_play = 0;
            m_invuln = 1'b0; m_key_prev = 1'b0; m_coll_prev = 1'b0;
            return;
        end
        m_key_prev  = key_now;
        m_coll_prev = colliding;
        case (m_phase)
            P_ATTRACT, P_OVER, P_WIN: begin
                if (sedge) begin
                    m_phase = P_RESPAWN; m_lives = LI; m_elapsed = 0;
                end
            end
            P_RESPAWN: begin
                m_elapsed++;
                if (m_elapsed == RF) begin
                    m_phase = P_PLAYING; m_play = 0; m_invuln = INV_EN;
                end
            end
            P_PLAYING: begin
                if (hit) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_phase = P_DYING; m_elapsed = 0; m_invuln = 1'b0;
                end else if (goal) begin
                    m_phase = P_WIN; m_invuln = 1'b0;
                end else begin
                    m_play++;
                    m_invuln = INV_EN && (m_play < IFR);
                end
            end
            P_DYING: begin
                m_elapsed++;
                if (m_elapsed == DF) begin
                    m_phase = (m_lives == 0) ? P_OVER : P_RESPAWN;
                    m_elapsed = 0;
                end
            end
            default: m_phase = P_ATTRACT;
        endcase
    endtask

    task automatic check_model();
        bit exp_blink;
        exp_blink = m_invuln && (((IFR - 1 - m_play) & 8) != 0);
        check("state",      32'(game_state), 32'(m_phase));
        check("lives",      32'(lives),      32'(m_lives));
        check("player_rst", 32'(player_rst), 32'((m_phase == P_ATTRACT) || (m_phase == P_RESPAWN)));
        check("freeze",     32'(freeze),     32'(m_phase != P_PLAYING));
        check("invuln",     32'(invuln),     32'(m_invuln));
        check("blink",      32'(blink),      32'(exp_blink));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            model_step();
            #1;
            check_model();
        end
    endtask

    task automatic press_start();
        keycode = START; run(1); keycode = 8'h00;
    endtask

    initial begin
        Reset = 1'b1; run(3); Reset = 1'b0;
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_prst", 32'(player_rst), 32'd1);
        check("rst_freeze", 32'(freeze), 32'd1);

        run(2);
        press_start();
        check("start_respawn", 32'(game_state), 32'd3);
        run(29);
        check("respawn_last", 32'(game_state), 32'd3);
        check("respawn_prst", 32'(player_rst), 32'd1);
        run(1);
        check("play_entry", 32'(game_state), 32'd1);
        check("play_lives", 32'(lives), 32'd3);
        check("play_prst", 32'(player_rst), 32'd0);

        // held collision: exactly one life lost, DYING lasts 90 frames
        run(130);
        colliding = 1'b1; run(1);
        check("hit_state", 32'(game_state), 32'd2);
        check("hit_lives", 32'(lives), 32'd2);
        run(9); colliding = 1'b0; run(80);
        check("dying_last", 32'(game_state), 32'd2);
        run(1);
        check("dying_exit", 32'(game_state), 32'd3);
        run(30);

        for (int n = 1; n >= 0; n--) begin
            run(130);
            colliding = 1'b1; run(1); colliding = 1'b0;
            check("multi_lives", 32'(lives), 32'(n));
            run(90);
            if (n > 0) run(30);
        end
        check("game_over", 32'(game_state), 32'd4);
        check("over_freeze", 32'(freeze), 32'd1);
        colliding = 1'b1; run(3); colliding = 1'b0; run(1);
        check("over_ignore_hit", 32'(lives), 32'd0);

        keycode2 = START; run(5);
        check("held_start", 32'(game_state), 32'd3);
        check("restart_lives", 32'(lives), 32'd3);
        keycode2 = 8'h00; run(26);
        check("replay", 32'(game_state), 32'd1);

        run(130);
        player_y = 10'(GY); player_x = 10'd150; colliding = 1'b1; run(1);
        colliding = 1'b0; player_y = '0;
        check("hit_beats_goal", 32'(game_state), 32'd2);
        run(120);
        run(130);
        player_y = 10'(GY); player_x = 10'd206; run(3);
        check("goal_x_206", 32'(game_state), 32'd1);
        player_x = 10'd205; run(1);
        check("goal_x_205", 32'(game_state), 32'd5);
        player_y = '0;

        press_start(); run(30); run(130);
        player_y = 10'(GY); player_x = 10'd119; run(2);
        check("goal_x_119", 32'(game_state), 32'd1);
        player_x = 10'd120; run(1);
        check("goal_x_120", 32'(game_state), 32'd5);
        player_y = '0;

        // reset while DYING with its timer at 40
        press_start(); run(30); run(130);
        colliding = 1'b1; run(1); colliding = 1'b0; run(49);
        check("pre_reset", 32'(game_state), 32'd2);
        Reset = 1'b1; run(1); Reset = 1'b0;
        check("midreset_state", 32'(game_state), 32'd0);
        check("midreset_lives", 32'(lives), 32'd3);
        check("midreset_prst", 32'(player_rst), 32'd1);

        press_start(); run(30); run(49);
        colliding = 1'b1; run(1); colliding = 1'b0;
`ifdef INVULN_EN
        check("invuln_ignore", 32'(game_state), 32'd1);
        check("invuln_lives", 32'(lives), 32'd3);
        run(70);
        colliding = 1'b1; run(1); colliding = 1'b0;
        check("invuln_expired", 32'(game_state), 32'd2);
`else
        check("nomask_hit", 32'(game_state), 32'd2);
`endif
        run(5);

        for (int i = 0; i < 4000; i++) begin
            Reset    = ($urandom_range(0, 499) == 0);
            keycode  = ($urandom_range(0, 24) == 0) ? START : 8'($urandom_range(0, 255));
            keycode2 = ($urandom_range(0, 49) == 0) ? START : 8'h00;
            if ($urandom_range(0, 9) == 0) colliding = ~colliding;
            player_y = ($urandom_range(0, 59) == 0) ? 10'(GY) : 10'($urandom_range(0, 1023));
            player_x = 10'($urandom_range(100, 230));
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-rate game-flow controller that sequences the player datapath through attract, play, death, respawn, game-over and win phases. It sits between the keyboard/collision sources and the player block. It drives the player's reset and a freeze hold, and owns the authoritative lives count shown by the HUD. It runs on the same frame clock as the player and sprite logic.

## Interface
Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3)
- DEATH_FRAMES, 90, frames spent in DYING
- RESPAWN_FRAMES, 30, frames player is held in reset in RESPAWN
- INVULN_FRAMES, 120, post-respawn collision-mask window (INVULN_EN only)
- START_KEY, 8'h28, keycode that starts/restarts a game (Enter)
- GOAL_Y, 74, player Y that counts as the goal floor
- GOAL_X_MIN / GOAL_X_MAX, 120 / 205, goal X window, inclusive

Ports:
- frame_clk  in  1  frame clock; the only clock
- Reset  in  1  synchronous, active-high reset
- keycode  in  8  keyboard slot 1
- keycode2  in  8  keyboard slot 2
- colliding  in  1  player/hazard overlap, level-sensitive
- player_x  in  10  player X position
- player_y  in  10  player Y position
- player_rst  out  1  drives the player block's Reset
- freeze  out  1  high = sprite/hazard motion must hold
- lives  out  2  remaining lives
- game_state  out  3  current state encoding
- invuln  out  1  collision mask active
- blink  out  1  sprite-hide strobe while invulnerable

## Operation
- States and encodings: ATTRACT=0, PLAYING=1, DYING=2, RESPAWN=3, GAME_OVER=4, WIN=5. Codes 6 and 7 are illegal and go to ATTRACT on the next edge.
- start_edge: START_KEY is present in either key slot this frame and was absent last frame. Use a 1-bit registered history.
- hit: colliding=1, the registered prior colliding=0, and invuln=0.
- goal: player_y==GOAL_Y and GOAL_X_MIN<=player_x<=GOAL_X_MAX.
- ATTRACT: player_rst=1, freeze=1. On start_edge: lives<=LIVES_INIT, timer<=RESPAWN_FRAMES-1, go to RESPAWN.
- RESPAWN: player_rst=1, freeze=1. Timer decrements each frame. At timer==0: go to PLAYING and load invuln_timer<=INVULN_FRAMES-1.
- PLAYING: player_rst=0, freeze=0.
  - hit: lives<=lives-1 (saturating at 0), timer<=DEATH_FRAMES-1, go to DYING.
  - else goal: go to WIN.
  - hit and goal in the same frame: hit wins.
- DYING: player_rst=0, freeze=1. Timer decrements. At timer==0: if lives==0 go to GAME_OVER, else load timer<=RESPAWN_FRAMES-1 and go to RESPAWN.
- GAME_OVER and WIN: player_rst=0, freeze=1. On start_edge: same action as in ATTRACT.
- Collisions in any state other than PLAYING are ignored and never alter lives.
- Timer width: 8 bits. Every parameter must be at most 255.
- Lives arithmetic is 2-bit and never wraps below 0.

## Timing
- All outputs are registered and update on the frame_clk edge that samples the causing input. The effect is visible one frame after the input is applied.
- Reset values: game_state=ATTRACT, lives=LIVES_INIT, player_rst=1, freeze=1, invuln=0, blink=0, timers=0, key/collision history=0.
- Reset asserted mid-game returns every register to its reset value on that edge. Reset has priority over all transitions.
- Time in DYING is exactly DEATH_FRAMES frames. Time in RESPAWN is exactly RESPAWN_FRAMES frames.
- A held START_KEY produces exactly one start_edge. A held colliding produces exactly one hit.

## Configuration
- Macro INVULN_EN.
- Defined:
  - invuln=1 for the INVULN_FRAMES frames following entry into PLAYING from RESPAWN.
  - invuln_timer decrements only while in PLAYING.
  - blink = invuln & invuln_timer[3].
  - invuln clears immediately on leaving PLAYING.
- Undefined: invuln and blink are tied to 0, invuln_timer does not exist, and hit ignores the mask.

## Test plan
- Reset, then press START_KEY for one frame -> RESPAWN with player_rst=1 for 30 frames, then PLAYING with lives=3.
- colliding held high for 10 frames while PLAYING (INVULN_EN undefined) -> one decrement to lives=2, DYING for 90 frames, then RESPAWN.
- Three separate hits -> lives reaches 0, DYING exits to GAME_OVER, freeze=1; START_KEY press -> lives=3, RESPAWN.
- player_y=74, player_x=150 and a collision edge in the same frame -> DYING, not WIN. With player_x=206 and no collision -> stays PLAYING.
- INVULN_EN defined, collision edge at frame 50 after respawn -> ignored, lives unchanged, blink toggles every 8 frames. Collision edge at frame 121 -> DYING.
- Reset asserted during DYING at timer=40 -> next edge ATTRACT, lives=3, player_rst=1, timers=0.
